multicycle_control_fsm: RTL



---
 rtl/multicycle_control_fsm_if.sv | 35 +++
 rtl/multicycle_control_fsm.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath/memory side (slave).
// Op/Zero/MemReady flow into the sequencer; every select, enable and pulse flows out.
interface multicycle_control_fsm_if;
  logic [6:0] Op;
  logic       Zero;
  logic       MemReady;
  logic       MemReq;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic       InstrDone;
  logic       BusError;
  logic [3:0] DbgState;

  // MemReq/MemReady form the memory handshake: the access is held (MemReq=1) until the
  // cycle in which MemReady=1, which completes it; no other signal qualifies the transfer.
  modport master (
    input  Op, Zero, MemReady,
    output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, InstrDone, BusError, DbgState
  );

  modport slave (
    output Op, Zero, MemReady,
    input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, InstrDone, BusError, DbgState
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V sequencer: fetch/decode/execute/memory/writeback over one ALU and one
// memory port, with a MemReady wait timeout, retire pulse and bus-error pulse.
module multicycle_control_fsm #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_is_store;

  logic       w_mem_state, w_timeout;
  logic       w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_reg_write;
  logic       w_pc_update, w_branch, w_instr_done;
  logic [1:0] w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src, w_imm_src;

  // Wait-counting states: the counter only advances while one of these stalls on MemReady.
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  assign w_timeout   = w_mem_state && !bus.MemReady && (r_wait_cnt == CNT_W'(WAIT_LIMIT));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (bus.MemReady) w_next = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = r_is_store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.MemReady) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (bus.MemReady) w_next = S_FETCH;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
    if (w_timeout) w_next = S_FETCH;
  end

  // Any cycle that is not a stall (state change or timeout) zeroes the counter, so every
  // entry into a wait-counting state starts from 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_is_store <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_mem_state && !bus.MemReady && !w_timeout) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                                             r_wait_cnt <= '0;
      if (r_state == S_DECODE) r_is_store <= (bus.Op == OP_SW);
    end
  end

  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_instr_done = 1'b0;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_result_src = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = bus.MemReady;
        w_pc_update  = bus.MemReady;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_req    = 1'b1;
        w_mem_write  = !w_timeout;
        w_adr_src    = 1'b1;
        w_instr_done = bus.MemReady;
      end
      S_EXECUTER: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BEQ: begin
        w_alu_src_a  = 2'b10;
        w_alu_op     = 2'b01;
        w_branch     = 1'b1;
        w_instr_done = 1'b1;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (bus.Op)
      OP_SW:   w_imm_src = 2'b01;
      OP_BEQ:  w_imm_src = 2'b10;
      OP_JAL:  w_imm_src = 2'b11;
      default: w_imm_src = 2'b00;
    endcase
  end

  // The reset FETCH state would otherwise present MemReq=1, so every output is gated by rst.
  assign bus.MemReq    = rst & w_mem_req;
  assign bus.MemWrite  = rst & w_mem_write;
  assign bus.AdrSrc    = rst & w_adr_src;
  assign bus.IRWrite   = rst & w_ir_write;
  assign bus.PCWrite   = rst & (w_pc_update | (w_branch & bus.Zero));
  assign bus.RegWrite  = rst & w_reg_write;
  assign bus.ALUSrcA   = rst ? w_alu_src_a  : 2'b00;
  assign bus.ALUSrcB   = rst ? w_alu_src_b  : 2'b00;
  assign bus.ALUOp     = rst ? w_alu_op     : 2'b00;
  assign bus.ResultSrc = rst ? w_result_src : 2'b00;
  assign bus.ImmSrc    = rst ? w_imm_src    : 2'b00;
  assign bus.InstrDone = rst & w_instr_done;
  assign bus.BusError  = rst & w_timeout;
  assign bus.DbgState  = r_state;

endmodule
